cpu_sequencer: RTL and testbench

Fetch/execute sequencer that drives the `control` datapath (decoder, A/D/*A memory, ALU, condition).
- Owns the program counter and fetches instruction words from an external ROM over a req/ack handshake.
- Presents each fetched word to `control` for exactly one execute cycle, asserting the register-write enable for that cycle only.
- Updates PC from `jmp_if`/`A`, and provides run, single-step, halt-request, jump-to-self halt detection and ROM-timeout fault.

---
 rtl/cpu_sequencer_if.sv | 22 ++
 rtl/cpu_sequencer.sv | 110 +++++++++++
 tb/tb_cpu_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Instruction-ROM fetch port of the fetch/execute sequencer.
// The sequencer is the master; the ROM answers req with a one-cycle ack plus data.
interface cpu_sequencer_if;
  logic        req;
  logic [15:0] addr;
  logic        ack;
  logic [15:0] data;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns the PC, fetches words over the ROM handshake and
// presents each word to the control datapath for exactly one execute cycle.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  input  logic            halt_req,
  cpu_sequencer_if.master rom,
  output logic [15:0]     inst,
  output logic            exec_en,
  input  logic            jmp_if,
  input  logic [15:0]     A,
  output logic [15:0]     pc,
  output logic [15:0]     retired,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  // Counter value seen on the last FETCH cycle that may still accept an ack.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_reg;
  logic [15:0] pc_reg;
  logic [15:0] inst_reg;
  logic [15:0] retired_reg;
  logic [7:0]  tmo_reg;
  logic        step_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      inst_reg    <= 16'h0000;
      retired_reg <= 16'h0000;
      tmo_reg     <= 8'd0;
      step_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!halt_req && run) begin
            state_reg <= S_FETCH;
            step_reg  <= 1'b0;
          end else if (!halt_req && step) begin
            state_reg <= S_FETCH;
            step_reg  <= 1'b1;
          end
        end

        S_FETCH: begin
          // An ack arriving on the final allowed cycle still wins over the timeout.
          if (rom.ack) begin
            inst_reg  <= rom.data;
            tmo_reg   <= 8'd0;
            state_reg <= S_EXEC;
          end else begin
            tmo_reg <= tmo_reg + 8'd1;
            if (tmo_reg == TMO_LAST) begin
              state_reg <= S_FAULT;
            end
          end
        end

        S_EXEC: begin
          pc_reg <= jmp_if ? A : pc_reg + 16'd1;
          if (retired_reg != 16'hFFFF) begin
            retired_reg <= retired_reg + 16'd1;
          end
          if (jmp_if && (A == pc_reg)) begin
            state_reg <= S_HALT;
          end else if (halt_req || step_reg || !run) begin
            state_reg <= S_IDLE;
            step_reg  <= 1'b0;
          end else begin
            state_reg <= S_FETCH;
          end
        end

        S_HALT, S_FAULT: begin
          state_reg <= state_reg;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign rom.req  = (state_reg == S_FETCH);
  assign rom.addr = pc_reg;
  assign inst     = inst_reg;
  assign exec_en  = (state_reg == S_EXEC);
  assign pc       = pc_reg;
  assign retired  = retired_reg;
  assign halted   = (state_reg == S_HALT);
  assign fault    = (state_reg == S_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random run/step/halt traffic,
// checked against an instruction-level model of the program flow.
module tb_cpu_sequencer;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam int          ACK_TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step;
  logic        halt_req;
  logic [15:0] inst;
  logic        exec_en;
  logic        jmp_if;
  logic [15:0] A;
  logic [15:0] pc;
  logic [15:0] retired;
  logic        halted;
  logic        fault;

  cpu_sequencer_if rom_bus ();

  cpu_sequencer #(
    .RESET_PC    (RESET_PC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step     (step),
    .halt_req (halt_req),
    .rom      (rom_bus),
    .inst     (inst),
    .exec_en  (exec_en),
    .jmp_if   (jmp_if),
    .A        (A),
    .pc       (pc),
    .retired  (retired),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  // Program image and a toy control block: top nibble F means "jump to table entry".
  logic [15:0] rom_mem  [0:65535];
  logic [15:0] targ_tab [0:15];

  always_comb begin
    jmp_if = (inst[15:12] == 4'hF);
    A      = targ_tab[inst[3:0]];
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_exec   = 0;

  logic [15:0] m_pc;
  logic [15:0] m_ret;
  logic        m_halt;
  logic        m_fault;

  int rom_wait  = 0;
  int wait_left = 0;
  bit rom_mute  = 1'b0;
  bit force_ack = 1'b0;
  bit prev_req  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction-level model: every retired word moves the PC by the program's rules.
  task automatic observe();
    logic [15:0] w;
    logic [15:0] tgt;
    check("pc", 32'(pc), 32'(m_pc));
    check("retired", 32'(retired), 32'(m_ret));
    check("halted", 32'(halted), 32'(m_halt));
    check("fault", 32'(fault), 32'(m_fault));
    if (m_halt || m_fault) check("req_dead", 32'(rom_bus.req), 32'd0);
    if (rom_bus.req) check("rom_addr", 32'(rom_bus.addr), 32'(m_pc));
    if (exec_en) begin
      w = rom_mem[m_pc];
      check("inst", 32'(inst), 32'(w));
      n_exec++;
      if (w[15:12] == 4'hF) begin
        tgt = targ_tab[w[3:0]];
        if (tgt == m_pc) m_halt = 1'b1;
        m_pc = tgt;
      end else begin
        m_pc = m_pc + 16'd1;
      end
      if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
    end
  endtask

  // ROM responder: acks after rom_wait idle cycles from the start of each fetch.
  task automatic rom_drive();
    if (force_ack) begin
      rom_bus.ack  = 1'b1;
      rom_bus.data = 16'hBEEF;
    end else if (rom_bus.req && !rom_mute) begin
      if (!prev_req) wait_left = rom_wait;
      if (wait_left == 0) begin
        rom_bus.ack  = 1'b1;
        rom_bus.data = rom_mem[rom_bus.addr];
      end else begin
        wait_left--;
        rom_bus.ack  = 1'b0;
        rom_bus.data = 16'($urandom);
      end
    end else begin
      rom_bus.ack  = 1'b0;
      rom_bus.data = 16'($urandom);
    end
    prev_req = rom_bus.req;
  endtask

  task automatic tick(input bit obs = 1'b1);
    @(posedge clk);
    #1;
    if (obs) observe();
    rom_drive();
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_ret   = 16'h0000;
    m_halt  = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    run       = 1'b0;
    step      = 1'b0;
    halt_req  = 1'b0;
    force_ack = 1'b0;
    rom_mute  = 1'b0;
    tick(1'b0);
    check("rst_req", 32'(rom_bus.req), 32'd0);
    check("rst_exec", 32'(exec_en), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_pc", 32'(pc), 32'(RESET_PC));
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst          = 1'b1;
    run          = 1'b0;
    step         = 1'b0;
    halt_req     = 1'b0;
    rom_bus.ack  = 1'b0;
    rom_bus.data = 16'h0000;
    for (int i = 0; i < 65536; i++) rom_mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    for (int i = 0; i < 16; i++) targ_tab[i] = 16'($urandom);
    targ_tab[0] = 16'h0020;
    targ_tab[1] = 16'hFFFF;
    model_reset();
    do_reset();

    // Straight-line code with a zero-wait ROM: one retire every second cycle.
    run = 1'b1;
    rom_wait = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("cadence", 32'(exec_en), 32'(i % 2 == 0));
      if (i == 8) run = 1'b0;
    end
    tick();
    check("line_pc", 32'(pc), 32'd4);
    check("line_ret", 32'(retired), 32'd4);
    check("line_req", 32'(rom_bus.req), 32'd0);

    // Jump from 5 to 0x20, which then jumps to itself.
    rom_mem[5]     = 16'hF000;
    rom_mem[16'h20] = 16'hF000;
    run = 1'b1;
    for (int i = 0; i < 60 && !halted; i++) begin
      rom_wait = $urandom_range(0, 2);
      tick();
    end
    check("jump_halted", 32'(halted), 32'd1);
    check("jump_pc", 32'(pc), 32'h20);
    check("jump_ret", 32'(retired), 32'd7);
    repeat (4) tick();

    // Two wait states still complete; a silent ROM faults after ACK_TIMEOUT cycles.
    do_reset();
    run = 1'b1;
    rom_wait = 2;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exec_en) begin
        got = 1'b1;
        break;
      end
    end
    check("to_exec", 32'(got), 32'd1);
    rom_mute = 1'b1;
    for (int k = 1; k <= ACK_TIMEOUT; k++) begin
      tick();
      check("to_req", 32'(rom_bus.req), 32'd1);
    end
    m_fault = 1'b1;
    tick();
    check("to_req_drop", 32'(rom_bus.req), 32'd0);
    check("to_inst", 32'(inst), 32'(rom_mem[0]));
    repeat (3) tick();
    do_reset();

    // Single step; a second step pulse during the fetch is ignored.
    rom_wait = 1;
    n_exec = 0;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_req", 32'(rom_bus.req), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (6) tick();
    check("step_count", 32'(n_exec), 32'd1);
    check("step_pc", 32'(pc), 32'd1);
    check("step_req_idle", 32'(rom_bus.req), 32'd0);

    // Halt request while fetching 0xFFFF: that word retires and pc wraps to 0.
    do_reset();
    rom_mem[0]       = 16'hF001;
    rom_mem[16'hFFFF] = 16'h0123;
    run = 1'b1;
    rom_wait = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rom_bus.req && rom_bus.addr == 16'hFFFF) begin
        got = 1'b1;
        break;
      end
    end
    check("wrap_fetch", 32'(got), 32'd1);
    halt_req = 1'b1;
    repeat (3) tick();
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_ret", 32'(retired), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_hold", 32'(rom_bus.req), 32'd0);
    end

    // Reset in the middle of a fetch, with a stray ack on the following cycle.
    halt_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rom_bus.req) begin
        got = 1'b1;
        break;
      end
    end
    check("mid_fetch", 32'(got), 32'd1);
    rst = 1'b1;
    run = 1'b0;
    force_ack = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    model_reset();
    tick();
    force_ack = 1'b0;
    check("mid_inst", 32'(inst), 32'd0);
    check("mid_ret", 32'(retired), 32'd0);
    check("mid_req", 32'(rom_bus.req), 32'd0);
    tick();

    // Random run/step/halt traffic and ROM wait states.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run      = ($urandom_range(0, 9) != 0);
      step     = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 15) == 0);
      rom_wait = $urandom_range(0, 2);
      tick();
      if (halted) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
